sipo_frame_ctrl: RTL and testbench

Frame-level controller for the serial-in/parallel-out path. It watches a serial line and detects a start bit. It then sequences WIDTH data-bit shifts into an internal SIPO register, checks optional parity and the stop bit, and presents the assembled word on a parallel port with a valid/ready handshake. It sits between a raw serial input (one bit per `en` strobe) and any parallel consumer, replacing free-running SIPO shifting with framed, error-checked capture.

---
 rtl/sipo_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_ctrl
//  Description : Framed serial-to-parallel receiver. Detects a start bit,
//                shifts WIDTH data bits LSB-first, checks optional even parity
//                and the stop bit, and presents the word on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             en,
    output logic [WIDTH-1:0] po,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic             r_par_acc;
    logic             r_par_bad;
    logic [WIDTH-1:0] r_po;
    logic             r_valid;
    logic             r_busy;
    logic             r_ferr;
    logic             r_perr;
    logic             r_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_par_acc <= 1'b0;
            r_par_bad <= 1'b0;
            r_po      <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;

            // Consumer handshake runs every clock; a coincident delivery below overrides it.
            if (r_valid && ready)
                r_valid <= 1'b0;

            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!si) begin
                            r_state   <= S_DATA;
                            r_cnt     <= '0;
                            r_par_acc <= 1'b0;
                            r_par_bad <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_sr      <= {si, r_sr[WIDTH-1:1]};
                        r_par_acc <= r_par_acc ^ si;
                        r_cnt     <= r_cnt + c_ONE;
                        if (r_cnt == c_LAST)
                            r_state <= (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end
                    S_PAR: begin
                        r_par_bad <= r_par_acc ^ si;
                        r_state   <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!si) begin
                            r_ferr <= 1'b1;
                            r_perr <= r_par_bad;
                        end else if (r_par_bad) begin
                            r_perr <= 1'b1;
                        end else if (!r_valid || ready) begin
                            r_po    <= r_sr;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign po         = r_po;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_frame_ctrl
//  Description : Directed self-checking bench for sipo_frame_ctrl (no-parity
//                and even-parity instances, WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       si, en, ready;
    logic [3:0] po;
    logic       valid, busy, frame_err, parity_err, overrun;
    logic       si1, en1, ready1;
    logic [3:0] po1;
    logic       valid1, busy1, frame_err1, parity_err1, overrun1;

    int   n_checks = 0;
    int   n_errors = 0;
    logic seen_ferr, seen_perr, seen_perr1;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(0)) u_dut (
        .clk(clk), .rst(rst), .si(si), .en(en), .po(po), .valid(valid),
        .ready(ready), .busy(busy), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1)) u_dut_par (
        .clk(clk), .rst(rst), .si(si1), .en(en1), .po(po1), .valid(valid1),
        .ready(ready1), .busy(busy1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        seen_ferr  = seen_ferr | frame_err;
        seen_perr  = seen_perr | parity_err;
        seen_perr1 = seen_perr1 | parity_err1;
    endtask

    // fr[0] is the first bit on the line (start bit); busy must hold until the last edge.
    task automatic send0(input string tag, input logic [7:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            si = fr[i];
            en = 1'b1;
            tick();
            check({tag, "_busy"}, {31'd0, busy}, {31'd0, (i < n - 1)});
        end
        en = 1'b0;
        si = 1'b1;
    endtask

    task automatic send1(input string tag, input logic [7:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            si1 = fr[i];
            en1 = 1'b1;
            tick();
            check({tag, "_busy"}, {31'd0, busy1}, {31'd0, (i < n - 1)});
        end
        en1 = 1'b0;
        si1 = 1'b1;
    endtask

    initial begin
        logic [7:0] fr;
        rst = 1'b1; si = 1'b1; en = 1'b0; ready = 1'b0;
        si1 = 1'b1; en1 = 1'b0; ready1 = 1'b0;
        seen_ferr = 1'b0; seen_perr = 1'b0; seen_perr1 = 1'b0;
        tick();
        tick();
        check("rst_po",      {28'd0, po}, 32'h0);
        check("rst_valid",   {31'd0, valid}, 32'h0);
        check("rst_busy",    {31'd0, busy}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic frame: start, data 1,0,1,1, stop -> 4'b1101
        seen_ferr = 1'b0; seen_perr = 1'b0;
        send0("f1", 8'h3A, 6);
        check("f1_po",    {28'd0, po}, 32'hD);
        check("f1_valid", {31'd0, valid}, 32'h1);
        check("f1_errs",  {30'd0, seen_ferr, seen_perr}, 32'h0);

        // One-cycle ready consumes the word
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("hs_valid", {31'd0, valid}, 32'h0);
        check("hs_po",    {28'd0, po}, 32'hD);

        // Stop bit sampled low
        send0("fe", 8'h10, 6);
        check("fe_pulse", {31'd0, frame_err}, 32'h1);
        check("fe_valid", {31'd0, valid}, 32'h0);
        check("fe_po",    {28'd0, po}, 32'hD);
        tick();
        check("fe_pulse_end", {31'd0, frame_err}, 32'h0);
        check("fe_idle_busy", {31'd0, busy}, 32'h0);

        // Parity instance: data 1,1,0,0 with parity bit 1 (bad), then 0 (good)
        seen_perr1 = 1'b0;
        send1("pe", 8'h66, 7);
        check("pe_pulse", {31'd0, parity_err1}, 32'h1);
        check("pe_valid", {31'd0, valid1}, 32'h0);
        tick();
        check("pe_pulse_end", {31'd0, parity_err1}, 32'h0);
        seen_perr1 = 1'b0;
        send1("pg", 8'h46, 7);
        check("pg_po",    {28'd0, po1}, 32'h3);
        check("pg_valid", {31'd0, valid1}, 32'h1);
        check("pg_perr",  {31'd0, seen_perr1}, 32'h0);

        // Overrun: two good frames with ready held low
        send0("ov1", 8'h34, 6);
        check("ov1_po",  {28'd0, po}, 32'hA);
        check("ov1_ovr", {31'd0, overrun}, 32'h0);
        send0("ov2", 8'h2C, 6);
        check("ov2_po",    {28'd0, po}, 32'hA);
        check("ov2_valid", {31'd0, valid}, 32'h1);
        check("ov2_ovr",   {31'd0, overrun}, 32'h1);
        ready = 1'b1;
        tick();
        tick();
        tick();
        ready = 1'b0;
        check("ov_sticky", {31'd0, overrun}, 32'h1);
        check("ov_drain",  {31'd0, valid}, 32'h0);

        // Abort mid-frame after two data bits
        seen_ferr = 1'b0; seen_perr = 1'b0;
        en = 1'b1;
        si = 1'b0; tick();
        si = 1'b1; tick();
        si = 1'b0; tick();
        check("ab_busy_mid", {31'd0, busy}, 32'h1);
        en = 1'b0; si = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_po",      {28'd0, po}, 32'h0);
        check("ab_flags",   {26'd0, valid, busy, frame_err, parity_err, overrun, 1'b0}, 32'h0);
        check("ab_nopulse", {30'd0, seen_ferr, seen_perr}, 32'h0);
        send0("ab_new", 8'h3E, 6);
        check("ab_new_po",    {28'd0, po}, 32'hF);
        check("ab_new_valid", {31'd0, valid}, 32'h1);
        check("ab_nopulse2",  {30'd0, seen_ferr, seen_perr}, 32'h0);

        // Sparse strobes: en high on every third clock
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("sp_clear", {31'd0, valid}, 32'h0);
        fr = 8'h3A;
        for (int i = 0; i < 6; i++) begin
            si = fr[i];
            en = 1'b0; tick();
            en = 1'b0; tick();
            if (i == 5) check("sp_valid_17", {31'd0, valid}, 32'h0);
            en = 1'b1; tick();
        end
        en = 1'b0; si = 1'b1;
        check("sp_po",    {28'd0, po}, 32'hD);
        check("sp_valid", {31'd0, valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
